escrita_registradores: RTL and testbench
========================================

Name: escrita_registradores

Overview:
Writeback unit: the writer side of the NRISC register bank. Collects results from the ALU and the load path and buffers them in a small in-order queue. Issues at most one write per cycle into the 8x8-bit general bank or the 4x1-bit boolean bank. Also flags read-after-write conflicts for decode while writes are still pending.

Parameters:
PROF_FILA, 4, queue depth in entries; power of 2, minimum 2
LARG_DADO, 8, general register data width

Ports:
Clock  in  1  system clock; all state updates on posedge
Reset  in  1  synchronous, active-high
Halt  in  1  processor halt; freezes enqueue and dequeue
MemValido  in  1  load result offered
MemBool  in  1  1 = boolean destination
MemReg  in  3  destination index; boolean uses bits [1:0]
MemDado  in  8  load data; boolean uses bit 0
MemPronto  out  1  load result accepted this cycle when MemValido=1
UlaValido  in  1  ALU result offered
UlaBool  in  1  1 = boolean destination
UlaReg  in  3  destination index
UlaDado  in  8  ALU data
UlaPronto  out  1  ALU result accepted this cycle when UlaValido=1
RegLido1  in  3  decode read index, general bank
RegLido2  in  3  decode read index, general bank
BoolLido1  in  2  decode read index, boolean bank
BoolLido2  in  2  decode read index, boolean bank
Conflito  out  1  pending general write matches RegLido1 or RegLido2
ConflitoBool  out  1  pending boolean write matches BoolLido1 or BoolLido2
EscreveReg  out  1  general-bank write strobe
RegEscrito  out  3  general-bank write index
DadoEscrito  out  8  general-bank write data
EscreveBool  out  1  boolean-bank write strobe
BoolEscrito  out  2  boolean-bank write index
DadoBool  out  1  boolean-bank write data

Behaviour:
- Reset (sync): queue count, read pointer and write pointer go to 0. All registered outputs go to 0 (EscreveReg, RegEscrito, DadoEscrito, EscreveBool, BoolEscrito, DadoBool). Pending entries are discarded, including on reset mid-drain.
- Entry format: {bool, reg[2:0], dado[7:0]}. Boolean entries store MemReg/UlaReg[1:0] and data bit 0.
- Ready is computed from the registered count only; a same-cycle dequeue does not free a slot:
  - MemPronto = !Halt && count <= PROF_FILA-1
  - UlaPronto = !Halt && count + MemValido <= PROF_FILA-1
- Simultaneous offers: the Mem entry is enqueued before the Ula entry. Both are accepted only if 2 slots are free; with 1 free slot, Mem is accepted and Ula stalls.
- Enqueue happens when Valido && Pronto at a posedge. Count update = enqueues minus dequeue (range 0..PROF_FILA); the queue never over- or underflows.
- Dequeue: at a posedge where !Halt and count>0, the head is popped into the output registers.
  - General entry: EscreveReg=1, EscreveBool=0.
  - Boolean entry: EscreveBool=1, EscreveReg=0.
  - With no pop, both strobes go to 0; index and data hold their last values.
- Latency: an entry enqueued at edge N is on the outputs after edge N+1 at the earliest. Write order equals acceptance order, so a later write to the same register always lands last.
- Halt=1: no enqueue, no pop, both strobes go to 0 at the next edge, queue contents retained. Drain resumes the cycle after Halt falls.
- Conflito (combinational): set if any valid general queue entry, or the output stage with EscreveReg=1, has reg equal to RegLido1 or RegLido2. ConflitoBool uses the same rule against the boolean entries and BoolLido1/2. Entries being offered in the current cycle are not included.
- Pointers wrap modulo PROF_FILA.

Decomposition:
- Shared package (nrisc_pkg): LARG_REG=3, LARG_BOOL=2, LARG_DADO=8, and the writeback entry struct {bool, reg, dado}.
- Sub-module fila_escrita: synchronous FIFO with dual push (Mem slot, then Ula slot), single pop, count output, and a per-entry valid/index view used for conflict compare.
- Top level holds the ready logic, output registers and comparators.

Test Plan:
- Reset, then UlaValido with R3=0x5A -> one cycle later EscreveReg=1, RegEscrito=3, DadoEscrito=0x5A for exactly one cycle; EscreveBool=0.
- Same cycle, Mem R1=0x11 and Ula R1=0x22, queue empty -> both accepted; writes 0x11 then 0x22 on consecutive cycles.
- Both sources valid every cycle for 4 cycles, PROF_FILA=4 -> UlaPronto drops when count reaches 3, no entry lost or duplicated; all accepted writes emerge in acceptance order, one per cycle.
- Ula bool B2=1 (UlaBool=1, UlaReg=2, UlaDado=0x01) -> EscreveBool=1, BoolEscrito=2, DadoBool=1; EscreveReg=0.
- R5 queued, Halt=1, RegLido1=5 -> Conflito=1 and no strobes for the Halt duration; Halt=0 -> write of R5 issues, and Conflito=0 on the cycle after its strobe.
- 3 entries pending, Reset pulsed 1 cycle -> next cycle count=0, both strobes 0, Conflito=0, MemPronto=UlaPronto=1.

Source files
------------

// File: rtl/nrisc_pkg.sv
// Shared NRISC register-bank widths and the writeback queue entry format.
package nrisc_pkg;

  localparam int unsigned LARG_REG  = 3;
  localparam int unsigned LARG_BOOL = 2;
  localparam int unsigned LARG_DADO = 8;

  typedef struct packed {
    logic                 ehBool;
    logic [LARG_REG-1:0]  indice;
    logic [LARG_DADO-1:0] dado;
  } entradaEscrita_t;

  // Boolean destinations keep only index[1:0] and data bit 0.
  function automatic entradaEscrita_t montaEntrada(input logic                 ehBool,
                                                   input logic [LARG_REG-1:0]  indice,
                                                   input logic [LARG_DADO-1:0] dado);
    entradaEscrita_t e;
    e.ehBool = ehBool;
    e.indice = indice;
    e.dado   = dado;
    if (ehBool) begin
      e.indice = LARG_REG'(indice[LARG_BOOL-1:0]);
      e.dado   = LARG_DADO'(dado[0]);
    end
    return e;
  endfunction

endpackage

// File: rtl/fila_escrita.sv
// In-order writeback queue: Mem push lands before Ula push, one pop per cycle.
module fila_escrita
  import nrisc_pkg::*;
#(
  parameter int unsigned PROF_FILA = 4
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic                        PushMem,
  input  entradaEscrita_t             EntradaMem,
  input  logic                        PushUla,
  input  entradaEscrita_t             EntradaUla,
  input  logic                        Pop,
  output entradaEscrita_t             Cabeca,
  output logic [$clog2(PROF_FILA):0]  Contagem,
  output logic [PROF_FILA-1:0]        Validos,
  output entradaEscrita_t             Entradas [PROF_FILA]
);

  localparam int unsigned LARG_PTR  = $clog2(PROF_FILA);
  localparam int unsigned LARG_CONT = LARG_PTR + 1;

  entradaEscrita_t     memoria [PROF_FILA];
  logic [LARG_PTR-1:0] ptrLeitura;
  logic [LARG_PTR-1:0] ptrEscrita;
  logic [LARG_PTR-1:0] ptrUla;
  logic [LARG_PTR-1:0] desloc;

  assign ptrUla   = PushMem ? ptrEscrita + LARG_PTR'(1) : ptrEscrita;
  assign Cabeca   = memoria[ptrLeitura];
  assign Entradas = memoria;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      ptrLeitura <= '0;
      ptrEscrita <= '0;
      Contagem   <= '0;
    end else begin
      if (PushMem) memoria[ptrEscrita] <= EntradaMem;
      if (PushUla) memoria[ptrUla] <= EntradaUla;
      ptrEscrita <= ptrEscrita + LARG_PTR'(PushMem) + LARG_PTR'(PushUla);
      if (Pop) ptrLeitura <= ptrLeitura + LARG_PTR'(1);
      Contagem <= Contagem + LARG_CONT'(PushMem) + LARG_CONT'(PushUla) - LARG_CONT'(Pop);
    end
  end

  // Slot i is live when its distance from the read pointer is below the count.
  always_comb begin
    Validos = '0;
    desloc  = '0;
    for (int unsigned i = 0; i < PROF_FILA; i++) begin
      desloc     = LARG_PTR'(i) - ptrLeitura;
      Validos[i] = LARG_CONT'(desloc) < Contagem;
    end
  end

endmodule

// File: rtl/escrita_registradores.sv
// NRISC writeback unit: queues ALU/load results and writes one per cycle into the banks.
module escrita_registradores
  import nrisc_pkg::entradaEscrita_t;
  import nrisc_pkg::montaEntrada;
  import nrisc_pkg::LARG_REG;
  import nrisc_pkg::LARG_BOOL;
#(
  parameter int unsigned PROF_FILA = 4,
  parameter int unsigned LARG_DADO = 8
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Halt,
  input  logic                 MemValido,
  input  logic                 MemBool,
  input  logic [LARG_REG-1:0]  MemReg,
  input  logic [LARG_DADO-1:0] MemDado,
  output logic                 MemPronto,
  input  logic                 UlaValido,
  input  logic                 UlaBool,
  input  logic [LARG_REG-1:0]  UlaReg,
  input  logic [LARG_DADO-1:0] UlaDado,
  output logic                 UlaPronto,
  input  logic [LARG_REG-1:0]  RegLido1,
  input  logic [LARG_REG-1:0]  RegLido2,
  input  logic [LARG_BOOL-1:0] BoolLido1,
  input  logic [LARG_BOOL-1:0] BoolLido2,
  output logic                 Conflito,
  output logic                 ConflitoBool,
  output logic                 EscreveReg,
  output logic [LARG_REG-1:0]  RegEscrito,
  output logic [LARG_DADO-1:0] DadoEscrito,
  output logic                 EscreveBool,
  output logic [LARG_BOOL-1:0] BoolEscrito,
  output logic                 DadoBool
);

  localparam int unsigned LARG_CONT = $clog2(PROF_FILA) + 1;
  localparam int unsigned LARG_OCUP = LARG_CONT + 1;

  logic [LARG_CONT-1:0] contagem;
  logic [LARG_OCUP-1:0] ocupUla;
  logic [PROF_FILA-1:0] validos;
  entradaEscrita_t      entradas [PROF_FILA];
  entradaEscrita_t      cabeca;
  entradaEscrita_t      entradaMem;
  entradaEscrita_t      entradaUla;
  logic                 pushMem;
  logic                 pushUla;
  logic                 pop;

  // Readiness uses the registered count only, so a same-cycle pop never frees a slot.
  assign ocupUla    = LARG_OCUP'(contagem) + LARG_OCUP'(MemValido);
  assign MemPronto  = !Halt && (contagem <= LARG_CONT'(PROF_FILA - 1));
  assign UlaPronto  = !Halt && (ocupUla <= LARG_OCUP'(PROF_FILA - 1));
  assign pushMem    = MemValido && MemPronto;
  assign pushUla    = UlaValido && UlaPronto;
  assign pop        = !Halt && (contagem != '0);
  assign entradaMem = montaEntrada(MemBool, MemReg, MemDado);
  assign entradaUla = montaEntrada(UlaBool, UlaReg, UlaDado);

  fila_escrita #(
    .PROF_FILA (PROF_FILA)
  ) uFila (
    .Clock      (Clock),
    .Reset      (Reset),
    .PushMem    (pushMem),
    .EntradaMem (entradaMem),
    .PushUla    (pushUla),
    .EntradaUla (entradaUla),
    .Pop        (pop),
    .Cabeca     (cabeca),
    .Contagem   (contagem),
    .Validos    (validos),
    .Entradas   (entradas)
  );

  // Output stage: strobes pulse for one cycle per pop; index/data hold otherwise.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      EscreveReg  <= 1'b0;
      RegEscrito  <= '0;
      DadoEscrito <= '0;
      EscreveBool <= 1'b0;
      BoolEscrito <= '0;
      DadoBool    <= 1'b0;
    end else begin
      EscreveReg  <= 1'b0;
      EscreveBool <= 1'b0;
      if (pop) begin
        if (cabeca.ehBool) begin
          EscreveBool <= 1'b1;
          BoolEscrito <= cabeca.indice[LARG_BOOL-1:0];
          DadoBool    <= cabeca.dado[0];
        end else begin
          EscreveReg  <= 1'b1;
          RegEscrito  <= cabeca.indice;
          DadoEscrito <= cabeca.dado;
        end
      end
    end
  end

  // Hazard compare over queued entries plus the write currently on the outputs.
  always_comb begin
    Conflito     = EscreveReg && ((RegEscrito == RegLido1) || (RegEscrito == RegLido2));
    ConflitoBool = EscreveBool && ((BoolEscrito == BoolLido1) || (BoolEscrito == BoolLido2));
    for (int unsigned i = 0; i < PROF_FILA; i++) begin
      if (validos[i]) begin
        if (entradas[i].ehBool) begin
          ConflitoBool = ConflitoBool ||
                         (entradas[i].indice[LARG_BOOL-1:0] == BoolLido1) ||
                         (entradas[i].indice[LARG_BOOL-1:0] == BoolLido2);
        end else begin
          Conflito = Conflito ||
                     (entradas[i].indice == RegLido1) ||
                     (entradas[i].indice == RegLido2);
        end
      end
    end
  end

endmodule

// File: tb/tb_escrita_registradores.sv
// Directed vector bench for the writeback unit, plus a hand-written Halt-while-strobing sequence.
module tb_escrita_registradores;

  logic       Clock = 1'b0;
  logic       Reset, Halt;
  logic       MemValido, MemBool, MemPronto;
  logic [2:0] MemReg;
  logic [7:0] MemDado;
  logic       UlaValido, UlaBool, UlaPronto;
  logic [2:0] UlaReg;
  logic [7:0] UlaDado;
  logic [2:0] RegLido1, RegLido2;
  logic [1:0] BoolLido1, BoolLido2;
  logic       Conflito, ConflitoBool;
  logic       EscreveReg, EscreveBool, DadoBool;
  logic [2:0] RegEscrito;
  logic [7:0] DadoEscrito;
  logic [1:0] BoolEscrito;

  escrita_registradores #(.PROF_FILA(4), .LARG_DADO(8)) dut (
    .Clock(Clock), .Reset(Reset), .Halt(Halt),
    .MemValido(MemValido), .MemBool(MemBool), .MemReg(MemReg), .MemDado(MemDado), .MemPronto(MemPronto),
    .UlaValido(UlaValido), .UlaBool(UlaBool), .UlaReg(UlaReg), .UlaDado(UlaDado), .UlaPronto(UlaPronto),
    .RegLido1(RegLido1), .RegLido2(RegLido2), .BoolLido1(BoolLido1), .BoolLido2(BoolLido2),
    .Conflito(Conflito), .ConflitoBool(ConflitoBool),
    .EscreveReg(EscreveReg), .RegEscrito(RegEscrito), .DadoEscrito(DadoEscrito),
    .EscreveBool(EscreveBool), .BoolEscrito(BoolEscrito), .DadoBool(DadoBool)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic rst, halt, mv, mb; logic [2:0] mr; logic [7:0] md;
    logic uv, ub; logic [2:0] ur; logic [7:0] ud;
    logic [2:0] r1, r2; logic [1:0] b1, b2;
  } entrada_t;

  typedef struct packed {
    logic mp, up, cf, cb, er; logic [2:0] re; logic [7:0] de;
    logic eb; logic [1:0] be; logic db;
  } saida_t;

  typedef struct {
    entrada_t e;
    logic     chk;
    saida_t   s;
  } vetor_t;

  vetor_t tab[$];
  int     total = 0;
  int     passou = 0;

  function automatic entrada_t ent(input int rst, halt, mv, mb, mr, md, uv, ub, ur, ud, r1, r2, b1, b2);
    return {1'(rst), 1'(halt), 1'(mv), 1'(mb), 3'(mr), 8'(md),
            1'(uv), 1'(ub), 3'(ur), 8'(ud), 3'(r1), 3'(r2), 2'(b1), 2'(b2)};
  endfunction

  function automatic entrada_t ocioso(input int r1, b1, b2);
    return ent(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, r1, 7, b1, b2);
  endfunction

  function automatic saida_t sai(input int mp, up, cf, cb, er, re, de, eb, be, db);
    return {1'(mp), 1'(up), 1'(cf), 1'(cb), 1'(er), 3'(re), 8'(de), 1'(eb), 2'(be), 1'(db)};
  endfunction

  function automatic saida_t le();
    return {MemPronto, UlaPronto, Conflito, ConflitoBool, EscreveReg, RegEscrito, DadoEscrito,
            EscreveBool, BoolEscrito, DadoBool};
  endfunction

  task automatic add(input entrada_t e, input logic chk, input saida_t s);
    tab.push_back('{e, chk, s});
  endtask

  task automatic aplica(input entrada_t e);
    Reset = e.rst; Halt = e.halt;
    MemValido = e.mv; MemBool = e.mb; MemReg = e.mr; MemDado = e.md;
    UlaValido = e.uv; UlaBool = e.ub; UlaReg = e.ur; UlaDado = e.ud;
    RegLido1 = e.r1; RegLido2 = e.r2; BoolLido1 = e.b1; BoolLido2 = e.b2;
  endtask

  task automatic confere(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    total++;
    if (atual !== esperado)
      $display("FAIL %s: got 0x%0h expected 0x%0h", nome, atual, esperado);
    else
      passou++;
  endtask

  initial begin
    aplica(ent(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7, 7, 3, 3));

    // Columns: rst halt | mv mb mr md | uv ub ur ud | r1 r2 b1 b2  ->  mp up cf cb | er re de | eb be db
    add(ent(1,0, 0,0,0,0,     0,0,0,0,     7,7,3,3), 1'b0, sai(0,0,0,0, 0,0,0,     0,0,0));
    add(ocioso(7,3,3),                                1'b1, sai(1,1,0,0, 0,0,0,     0,0,0));
    add(ent(0,0, 0,0,0,0,     1,0,3,'h5A,  7,7,3,3), 1'b1, sai(1,1,0,0, 0,0,0,     0,0,0));
    add(ocioso(3,3,3),                                1'b1, sai(1,1,1,0, 0,0,0,     0,0,0));
    add(ocioso(3,3,3),                                1'b1, sai(1,1,1,0, 1,3,'h5A,  0,0,0));
    add(ent(0,0, 1,0,1,'h11,  1,0,1,'h22,  7,7,3,3), 1'b1, sai(1,1,0,0, 0,3,'h5A,  0,0,0));
    add(ocioso(7,3,3),                                1'b1, sai(1,1,0,0, 0,3,'h5A,  0,0,0));
    add(ocioso(7,3,3),                                1'b1, sai(1,1,0,0, 1,1,'h11,  0,0,0));
    add(ocioso(7,3,3),                                1'b1, sai(1,1,0,0, 1,1,'h22,  0,0,0));
    // Both sources every cycle; Ula holds its stalled offer until taken.
    add(ent(0,0, 1,0,2,'hA1,  1,0,4,'hB1,  7,7,3,3), 1'b1, sai(1,1,0,0, 0,1,'h22,  0,0,0));
    add(ent(0,0, 1,0,2,'hA2,  1,0,4,'hB2,  7,7,3,3), 1'b1, sai(1,1,0,0, 0,1,'h22,  0,0,0));
    add(ent(0,0, 1,0,2,'hA3,  1,0,4,'hB3,  7,7,3,3), 1'b1, sai(1,0,0,0, 1,2,'hA1,  0,0,0));
    add(ent(0,0, 1,0,2,'hA4,  1,0,4,'hB3,  7,7,3,3), 1'b1, sai(1,0,0,0, 1,4,'hB1,  0,0,0));
    add(ent(0,0, 0,0,0,0,     1,0,4,'hB3,  7,7,3,3), 1'b1, sai(1,1,0,0, 1,2,'hA2,  0,0,0));
    add(ocioso(7,3,3),                                1'b1, sai(1,1,0,0, 1,4,'hB2,  0,0,0));
    add(ocioso(7,3,3),                                1'b1, sai(1,1,0,0, 1,2,'hA3,  0,0,0));
    add(ocioso(7,3,3),                                1'b1, sai(1,1,0,0, 1,2,'hA4,  0,0,0));
    add(ocioso(7,3,3),                                1'b1, sai(1,1,0,0, 1,4,'hB3,  0,0,0));
    // Boolean destinations, including data/index masking on the load path.
    add(ent(0,0, 0,0,0,0,     1,1,2,'h01,  7,7,3,3), 1'b1, sai(1,1,0,0, 0,4,'hB3,  0,0,0));
    add(ocioso(7,2,3),                                1'b1, sai(1,1,0,1, 0,4,'hB3,  0,0,0));
    add(ocioso(7,2,3),                                1'b1, sai(1,1,0,1, 0,4,'hB3,  1,2,1));
    add(ent(0,0, 1,1,5,'hFE,  0,0,0,0,     7,7,3,3), 1'b1, sai(1,1,0,0, 0,4,'hB3,  0,2,1));
    add(ocioso(7,3,1),                                1'b1, sai(1,1,0,1, 0,4,'hB3,  0,2,1));
    add(ocioso(7,3,3),                                1'b1, sai(1,1,0,0, 0,4,'hB3,  1,1,0));
    // Halt with R5 pending: no accept, no strobe, conflict held.
    add(ent(0,0, 1,0,5,'h55,  0,0,0,0,     7,7,3,3), 1'b1, sai(1,1,0,0, 0,4,'hB3,  0,1,0));
    add(ent(0,1, 0,0,0,0,     1,0,6,'h66,  5,7,3,3), 1'b1, sai(0,0,1,0, 0,4,'hB3,  0,1,0));
    add(ent(0,1, 0,0,0,0,     1,0,6,'h66,  5,7,3,3), 1'b1, sai(0,0,1,0, 0,4,'hB3,  0,1,0));
    add(ocioso(5,3,3),                                1'b1, sai(1,1,1,0, 0,4,'hB3,  0,1,0));
    add(ocioso(5,3,3),                                1'b1, sai(1,1,1,0, 1,5,'h55,  0,1,0));
    add(ocioso(5,3,3),                                1'b1, sai(1,1,0,0, 0,5,'h55,  0,1,0));
    // Reset while three entries are pending.
    add(ent(0,0, 1,0,1,'h01,  1,0,2,'h02,  7,7,3,3), 1'b1, sai(1,1,0,0, 0,5,'h55,  0,1,0));
    add(ent(0,0, 1,0,3,'h03,  1,0,4,'h04,  7,7,3,3), 1'b1, sai(1,1,0,0, 0,5,'h55,  0,1,0));
    add(ent(1,0, 0,0,0,0,     0,0,0,0,     3,7,3,3), 1'b1, sai(1,1,1,0, 1,1,'h01,  0,1,0));
    add(ocioso(3,3,3),                                1'b1, sai(1,1,0,0, 0,0,0,     0,0,0));
    add(ocioso(3,3,3),                                1'b1, sai(1,1,0,0, 0,0,0,     0,0,0));

    foreach (tab[i]) begin
      @(negedge Clock);
      aplica(tab[i].e);
      #1;
      if (tab[i].chk) confere($sformatf("vec%0d", i), 32'(le()), 32'(tab[i].s));
    end

    // Halt arriving while a strobe is on the outputs.
    @(negedge Clock); aplica(ent(0,0, 1,0,6,'h66, 1,0,4,'h44, 4,7,3,3)); #1;
    confere("h_oferta", 32'({MemPronto, UlaPronto}), 32'(2'b11));
    @(negedge Clock); aplica(ocioso(4,3,3)); #1;
    confere("h_confl_fila", 32'(Conflito), 32'(1'b1));
    @(negedge Clock); aplica(ent(0,1, 0,0,0,0, 0,0,0,0, 4,7,3,3)); #1;
    confere("h_halt_strobe", 32'({EscreveReg, RegEscrito, DadoEscrito, MemPronto, UlaPronto}),
            32'({1'b1, 3'd6, 8'h66, 2'b00}));
    @(negedge Clock); #1;
    confere("h_halt_congela", 32'({EscreveReg, RegEscrito, DadoEscrito, Conflito}),
            32'({1'b0, 3'd6, 8'h66, 1'b1}));
    @(negedge Clock); aplica(ocioso(4,3,3)); #1;
    confere("h_halt_segura", 32'({EscreveReg, MemPronto}), 32'(2'b01));
    @(negedge Clock); #1;
    confere("h_retoma", 32'({EscreveReg, RegEscrito, DadoEscrito, Conflito}),
            32'({1'b1, 3'd4, 8'h44, 1'b1}));
    @(negedge Clock); #1;
    confere("h_fim", 32'({EscreveReg, EscreveBool, Conflito}), 32'(3'b000));

    $display("%0d/%0d checks passed", passou, total);
    $finish;
  end

endmodule
